unsigned_seq_div_restoring: RTL

Unsigned sequential restoring divider, the inverse of the team's shift-and-add sequential multiplier. It accepts a DW-bit dividend and a VW-bit divisor on a start pulse and produces one quotient bit per clock by shift-left-and-subtract. It returns the quotient and remainder with a one-cycle done pulse. The block sits beside the multiplier in the arithmetic datapath, so a 12-bit product can be divided back by one of its 6-bit factors.

---
 rtl/seq_arith_pkg.sv | 20 ++
 rtl/div_step.sv | 26 ++
 rtl/unsigned_seq_div_restoring.sv | 124 ++++++++++++
 3 files changed

// File: rtl/seq_arith_pkg.sv
// Shared definitions for the sequential arithmetic blocks (divider and
// multiplier): default operand widths, the common FSM state encoding and the
// iteration counter width helper.
package seq_arith_pkg;

  localparam int DW_DEF = 12;  // dividend / product width
  localparam int VW_DEF = 6;   // divisor / factor width

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

  // Counter must index 0..DW-1; keep at least one bit for degenerate widths.
  function automatic int cnt_w(input int dw);
    return (dw > 1) ? $clog2(dw) : 1;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, compare against the divisor and subtract when it fits.
//   r_i      partial remainder in (always < d_i, so VW bits suffice)
//   q_msb_i  dividend/quotient MSB shifted in this step
//   d_i      divisor
//   r_o      partial remainder out
//   q_bit_o  quotient bit produced by this step
module div_step #(
  parameter int VW = 6
) (
  input  logic [VW-1:0] r_i,
  input  logic          q_msb_i,
  input  logic [VW-1:0] d_i,
  output logic [VW-1:0] r_o,
  output logic          q_bit_o
);

  logic [VW:0] t;

  // T is VW+1 bits; after a conditional subtract the result is < D, so the
  // top bit is always zero and only VW bits are carried forward.
  assign t       = {r_i, q_msb_i};
  assign q_bit_o = (t >= {1'b0, d_i});
  assign r_o     = q_bit_o ? VW'(t - {1'b0, d_i}) : t[VW-1:0];

endmodule

// File: rtl/unsigned_seq_div_restoring.sv
// Unsigned sequential restoring divider. One quotient bit per clock, DW
// cycles from accepted start to done; divide-by-zero finishes in one cycle.
//   clk, rst_n        clock, async active-low reset
//   start, a, b       request, dividend (DW), divisor (VW)
//   busy              iterating
//   done              one-cycle pulse, results valid
//   quotient          a / b (all ones when b == 0)
//   remainder         a % b (zero when b == 0)
//   div0              last operation had b == 0
module unsigned_seq_div_restoring
  import seq_arith_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int VW = VW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] a,
  input  logic [VW-1:0] b,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div0
);

  localparam int CW = cnt_w(DW);

  seq_state_e    state_q, state_d;
  logic [DW-1:0] q_q, q_d;
  logic [VW-1:0] r_q, r_d;
  logic [VW-1:0] d_q, d_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] quot_q, quot_d;
  logic [VW-1:0] rem_q, rem_d;
  logic          div0_q, div0_d;

  logic [VW-1:0] step_r;
  logic          step_qb;
  logic [DW-1:0] q_next;

  div_step #(.VW(VW)) u_step (
    .r_i     (r_q),
    .q_msb_i (q_q[DW-1]),
    .d_i     (d_q),
    .r_o     (step_r),
    .q_bit_o (step_qb)
  );

  // Dividend bits shift out the top while quotient bits fill in at the bottom.
  assign q_next = {q_q[DW-2:0], step_qb};

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    r_d     = r_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    div0_d  = div0_q;
    unique case (state_q)
      RUN: begin
        // start is ignored here, not queued
        q_d   = q_next;
        r_d   = step_r;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(DW - 1)) begin
          quot_d  = q_next;
          rem_d   = step_r;
          div0_d  = 1'b0;
          state_d = DONE;
        end
      end
      default: begin  // IDLE and DONE are both ready for a new request
        state_d = IDLE;
        if (start) begin
          if (b == '0) begin
            quot_d  = '1;
            rem_d   = '0;
            div0_d  = 1'b1;
            state_d = DONE;
          end else begin
            q_d     = a;
            r_d     = '0;
            d_d     = b;
            cnt_d   = '0;
            state_d = RUN;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      q_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      r_q     <= r_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      div0_q  <= div0_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign div0      = div0_q;

endmodule
